// File: rtl/input_conditioner.sv
// Button/switch front end: 2-FF synchronisers, per-button debounce with level/edge pulses,
// select-mode toggle and a switch snapshot taken on each debounced capture press.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DATA_W          = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn_cap_raw,
   input  logic              btn_sel_raw,
   input  logic [DATA_W-1:0] sw_raw,
   output logic              cap_level,
   output logic              cap_rise,
   output logic              cap_fall,
   output logic              sel_mode,
   output logic [DATA_W-1:0] sw_sync,
   output logic [DATA_W-1:0] sw_snap,
   output logic              snap_valid
);

   // One extra bit of headroom so the count can never wrap before it is compared.
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]        btn_raw;
   logic              sel_rise;
   logic [DATA_W-1:0] sw_s1_reg;
   logic [DATA_W-1:0] sw_s2_reg;
   logic [DATA_W-1:0] sw_snap_reg;
   logic              snap_valid_reg;
   logic              sel_mode_reg;

   assign btn_raw = {btn_sel_raw, btn_cap_raw};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic             s1_reg;
         logic             s2_reg;
         logic             level_reg;
         logic             level_d_reg;
         logic             level_next;
         logic             pressed;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         assign pressed = ~s2_reg;

         always_comb begin
            cnt_next   = '0;
            level_next = level_reg;
            if (pressed != level_reg) begin
               if (cnt_reg == CNT_LAST) begin
                  level_next = pressed;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end

         // Sync flops reset to 1 so a button held through reset debounces from released.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s1_reg      <= 1'b1;
               s2_reg      <= 1'b1;
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               level_d_reg <= 1'b0;
            end else begin
               s1_reg      <= btn_raw[gi];
               s2_reg      <= s1_reg;
               cnt_reg     <= cnt_next;
               level_reg   <= level_next;
               level_d_reg <= level_reg;
            end
         end

         if (gi == 0) begin : g_cap_out
            assign cap_level = level_reg;
            assign cap_rise  = level_reg & ~level_d_reg;
            assign cap_fall  = ~level_reg & level_d_reg;
         end else begin : g_sel_out
            assign sel_rise  = level_reg & ~level_d_reg;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_s1_reg      <= '0;
         sw_s2_reg      <= '0;
         sw_snap_reg    <= '0;
         snap_valid_reg <= 1'b0;
         sel_mode_reg   <= 1'b0;
      end else begin
         sw_s1_reg <= sw_raw;
         sw_s2_reg <= sw_s1_reg;
         if (cap_rise) begin
            sw_snap_reg    <= sw_s2_reg;
            snap_valid_reg <= 1'b1;
         end
         if (sel_rise) begin
            sel_mode_reg <= ~sel_mode_reg;
         end
      end
   end

   assign sw_sync    = sw_s2_reg;
   assign sw_snap    = sw_snap_reg;
   assign snap_valid = snap_valid_reg;
   assign sel_mode   = sel_mode_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4: reset, press/release,
// bounce rejection, select toggling, simultaneous presses and reset mid-count.
module tb_input_conditioner;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          btn_cap_raw;
   logic          btn_sel_raw;
   logic [DW-1:0] sw_raw;
   logic          cap_level;
   logic          cap_rise;
   logic          cap_fall;
   logic          sel_mode;
   logic [DW-1:0] sw_sync;
   logic [DW-1:0] sw_snap;
   logic          snap_valid;

   int tests = 0;
   int fails = 0;
   int rise_cnt = 0;
   int fall_cnt = 0;

   input_conditioner #(.DEBOUNCE_CYCLES(4), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_cap_raw (btn_cap_raw),
      .btn_sel_raw (btn_sel_raw),
      .sw_raw      (sw_raw),
      .cap_level   (cap_level),
      .cap_rise    (cap_rise),
      .cap_fall    (cap_fall),
      .sel_mode    (sel_mode),
      .sw_sync     (sw_sync),
      .sw_snap     (sw_snap),
      .snap_valid  (snap_valid)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, sample 1 ns later and tally capture pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      if (cap_rise === 1'b1) rise_cnt++;
      if (cap_fall === 1'b1) fall_cnt++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cap_level"},  32'(cap_level),  32'h0);
      check({tag, "_cap_rise"},   32'(cap_rise),   32'h0);
      check({tag, "_cap_fall"},   32'(cap_fall),   32'h0);
      check({tag, "_sel_mode"},   32'(sel_mode),   32'h0);
      check({tag, "_snap_valid"}, 32'(snap_valid), 32'h0);
      check({tag, "_sw_sync"},    32'(sw_sync),    32'h0);
      check({tag, "_sw_snap"},    32'(sw_snap),    32'h0);
   endtask

   initial begin
      // 1: reset with buttons released
      rst_n       = 1'b0;
      btn_cap_raw = 1'b1;
      btn_sel_raw = 1'b1;
      sw_raw      = 8'hA5;
      ticks(3);
      check_all_zero("t1_reset");
      rst_n = 1'b1;
      rise_cnt = 0;
      fall_cnt = 0;
      tick();
      check("t1_sw_sync_edge1", 32'(sw_sync), 32'h00);
      tick();
      check("t1_sw_sync_edge2", 32'(sw_sync), 32'hA5);
      ticks(5);
      check("t1_no_rise", 32'(rise_cnt), 32'd0);
      check("t1_no_fall", 32'(fall_cnt), 32'd0);
      check("t1_sel_mode", 32'(sel_mode), 32'h0);

      // 2: clean press and release of capture
      rise_cnt = 0;
      btn_cap_raw = 1'b0;
      ticks(5);
      check("t2_level_edge5", 32'(cap_level), 32'h0);
      tick();
      check("t2_level_edge6", 32'(cap_level), 32'h1);
      check("t2_rise_edge6", 32'(cap_rise), 32'h1);
      check("t2_valid_edge6", 32'(snap_valid), 32'h0);
      tick();
      check("t2_rise_edge7", 32'(cap_rise), 32'h0);
      check("t2_snap", 32'(sw_snap), 32'hA5);
      check("t2_valid_edge7", 32'(snap_valid), 32'h1);
      sw_raw = 8'h0F;
      ticks(4);
      check("t2_rise_count", 32'(rise_cnt), 32'd1);
      fall_cnt = 0;
      btn_cap_raw = 1'b1;
      ticks(5);
      check("t2_rel_edge5", 32'(cap_level), 32'h1);
      tick();
      check("t2_rel_edge6", 32'(cap_level), 32'h0);
      check("t2_fall_edge6", 32'(cap_fall), 32'h1);
      tick();
      check("t2_fall_edge7", 32'(cap_fall), 32'h0);
      check("t2_fall_count", 32'(fall_cnt), 32'd1);
      check("t2_snap_hold", 32'(sw_snap), 32'hA5);

      // 3: bounce on capture
      rise_cnt = 0;
      btn_cap_raw = 1'b0; ticks(3);
      btn_cap_raw = 1'b1; ticks(1);
      btn_cap_raw = 1'b0; ticks(2);
      btn_cap_raw = 1'b1; ticks(1);
      btn_cap_raw = 1'b0;
      ticks(5);
      check("t3_level_edge5", 32'(cap_level), 32'h0);
      check("t3_no_early_rise", 32'(rise_cnt), 32'd0);
      tick();
      check("t3_level_edge6", 32'(cap_level), 32'h1);
      check("t3_rise_edge6", 32'(cap_rise), 32'h1);
      ticks(3);
      check("t3_rise_count", 32'(rise_cnt), 32'd1);
      check("t3_snap", 32'(sw_snap), 32'h0F);
      btn_cap_raw = 1'b1;
      ticks(8);
      check("t3_released", 32'(cap_level), 32'h0);

      // 4: two select press/release cycles
      btn_sel_raw = 1'b0; ticks(6);
      check("t4_p1_edge6", 32'(sel_mode), 32'h0);
      tick();
      check("t4_p1_edge7", 32'(sel_mode), 32'h1);
      ticks(3);
      btn_sel_raw = 1'b1; ticks(10);
      check("t4_r1", 32'(sel_mode), 32'h1);
      btn_sel_raw = 1'b0; ticks(6);
      check("t4_p2_edge6", 32'(sel_mode), 32'h1);
      tick();
      check("t4_p2_edge7", 32'(sel_mode), 32'h0);
      ticks(3);
      btn_sel_raw = 1'b1; ticks(10);
      check("t4_r2", 32'(sel_mode), 32'h0);

      // 5: simultaneous presses
      sw_raw = 8'h3C;
      btn_cap_raw = 1'b0;
      btn_sel_raw = 1'b0;
      ticks(6);
      check("t5_cap_rise", 32'(cap_rise), 32'h1);
      check("t5_sel_before", 32'(sel_mode), 32'h0);
      check("t5_snap_before", 32'(sw_snap), 32'h0F);
      tick();
      check("t5_snap_after", 32'(sw_snap), 32'h3C);
      check("t5_sel_after", 32'(sel_mode), 32'h1);
      btn_cap_raw = 1'b1;
      btn_sel_raw = 1'b1;
      ticks(8);
      check("t5_cap_released", 32'(cap_level), 32'h0);
      check("t5_sel_hold", 32'(sel_mode), 32'h1);

      // 6a: reset while the capture counter is mid-count
      btn_cap_raw = 1'b0;
      ticks(4);
      rst_n = 1'b0;
      tick();
      check_all_zero("t6a");
      tick();

      // 6b: button still held as reset is released
      rst_n = 1'b1;
      rise_cnt = 0;
      ticks(5);
      check("t6b_level_edge5", 32'(cap_level), 32'h0);
      check("t6b_valid_edge5", 32'(snap_valid), 32'h0);
      tick();
      check("t6b_level_edge6", 32'(cap_level), 32'h1);
      check("t6b_rise_edge6", 32'(cap_rise), 32'h1);
      check("t6b_valid_edge6", 32'(snap_valid), 32'h0);
      tick();
      check("t6b_valid_edge7", 32'(snap_valid), 32'h1);
      check("t6b_snap", 32'(sw_snap), 32'h3C);
      check("t6b_rise_count", 32'(rise_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
